// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the byte-addressed MEM-stage data memory:
//   - access size codes (byte / half / word; 2'b11 is reserved)
//   - controller state encoding (CLEAR, IDLE, WAIT)
//   - misaligned(): flags accesses the array must not commit
// -----------------------------------------------------------------------------
package dm_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'b00,
      ST_IDLE  = 2'b01,
      ST_WAIT  = 2'b10
   } dm_state_t;

   // Half accesses need an even address, word accesses a 4-byte aligned one.
   // The reserved size code is reported as an error the same way.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr_lo[0];
         SZ_W:    bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dm_subword_mem_if.sv
// -----------------------------------------------------------------------------
// dm_subword_mem_if
// Request/response bundle between the MEM stage (master) and the data memory
// (slave).
//   req_valid/req_ready   request handshake
//   req_we/size/signed    access type
//   req_addr/wdata/pc     byte address, right-justified store data, trace pc
//   resp_valid            one-cycle response pulse
//   resp_rdata/resp_err   extended load data / misalignment flag
//   busy                  memory is clearing or waiting on latency
// -----------------------------------------------------------------------------
interface dm_subword_mem_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );

endinterface

// File: rtl/dm_byte_lane.sv
// -----------------------------------------------------------------------------
// dm_byte_lane
// Combinational little-endian lane steering.
//   i_size, i_addr_lo  access size and byte offset within the word
//   i_signed           loads: sign-extend (1) or zero-extend (0)
//   i_wdata            right-justified store data
//   i_rword            current array word
//   o_be               byte enables for the store
//   o_wlanes           store data replicated so every enabled lane sees its byte
//   o_rdata            extracted and extended load result (0 for reserved size)
// -----------------------------------------------------------------------------
module dm_byte_lane
   import dm_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wlanes,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

   // Store side: replicate data across lanes and let the enables pick the target.
   always_comb begin
      o_be     = 4'b0000;
      o_wlanes = 32'h0000_0000;
      case (i_size)
         SZ_B: begin
            o_be     = 4'b0001 << i_addr_lo;
            o_wlanes = {4{i_wdata[7:0]}};
         end
         SZ_H: begin
            o_be     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wlanes = {2{i_wdata[15:0]}};
         end
         SZ_W: begin
            o_be     = 4'b1111;
            o_wlanes = i_wdata;
         end
         default: begin
            o_be     = 4'b0000;
            o_wlanes = 32'h0000_0000;
         end
      endcase
   end

   // Load side: extract the addressed lane(s) and extend; word loads ignore i_signed.
   always_comb begin
      o_rdata = 32'h0000_0000;
      case (i_size)
         SZ_B:    o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_H:    o_rdata = {{16{i_signed & w_half[15]}}, w_half};
         SZ_W:    o_rdata = i_rword;
         default: o_rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/dm_subword_mem.sv
// -----------------------------------------------------------------------------
// dm_subword_mem
// Byte-addressed MEM-stage data memory supporting sb/sh/sw and lb/lbu/lh/lhu/lw.
//   clk, rst   clock and synchronous active-high reset (rst wins over requests)
//   bus        dm_subword_mem_if.slave request/response port
// Parameters:
//   ADDR_W        byte-address bits used; array holds 2**(ADDR_W-2) words
//   LATENCY       cycles from accept edge to resp_valid (1..15)
//   CLEAR_ON_RST  1: zero the array one word per cycle after reset
// Optional build macro DM_TRACE_EN: print every committed store with its pc.
// Stores commit and load data is captured on the accept edge; the response is
// either issued on that edge (LATENCY=1) or released after the WAIT countdown.
// -----------------------------------------------------------------------------
module dm_subword_mem
   import dm_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int LATENCY      = 1,
   parameter int CLEAR_ON_RST = 1
)(
   input  logic               clk,
   input  logic               rst,
   dm_subword_mem_if.slave    bus
);

   localparam int              IDX_W     = ADDR_W - 2;
   localparam int              DEPTH     = 2 ** IDX_W;
   localparam dm_state_t       RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
   localparam logic [3:0]      LAT_INIT  = 4'(LATENCY - 1);
   localparam bit              LONG_LAT  = (LATENCY > 1);
   localparam logic [IDX_W-1:0] CLR_LAST = '1;

   dm_state_t         r_state;
   dm_state_t         w_state_nxt;
   logic [IDX_W-1:0]  r_clr_cnt;
   logic [3:0]        r_lat_cnt;
   logic [31:0]       r_mem [DEPTH];

   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_err;
   logic [31:0]       r_hold_rdata;
   logic              r_hold_err;

   logic [IDX_W-1:0]  w_idx;
   logic [31:0]       w_rword;
   logic              w_ready;
   logic              w_accept;
   logic              w_err;
   logic              w_do_store;
   logic [3:0]        w_be;
   logic [31:0]       w_wlanes;
   logic [31:0]       w_ldata;
   logic [31:0]       w_resp_data;
   logic              w_unused_hi;

   assign w_idx       = bus.req_addr[ADDR_W-1:2];
   assign w_rword     = r_mem[w_idx];
   assign w_ready     = (r_state == ST_IDLE);
   // rst on the same edge suppresses the accept and therefore any write.
   assign w_accept    = bus.req_valid & w_ready & ~rst;
   assign w_err       = misaligned(bus.req_size, bus.req_addr[1:0]);
   assign w_do_store  = w_accept & bus.req_we & ~w_err;
   assign w_resp_data = (bus.req_we | w_err) ? 32'h0000_0000 : w_ldata;
   assign w_unused_hi = ^bus.req_addr[31:ADDR_W];

   dm_byte_lane u_lane (
      .i_size    (bus.req_size),
      .i_addr_lo (bus.req_addr[1:0]),
      .i_signed  (bus.req_signed),
      .i_wdata   (bus.req_wdata),
      .i_rword   (w_rword),
      .o_be      (w_be),
      .o_wlanes  (w_wlanes),
      .o_rdata   (w_ldata)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RST_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: CLEAR sweeps the array, IDLE accepts, WAIT counts down latency.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_cnt == CLR_LAST) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            if (w_accept && LONG_LAT) begin
               w_state_nxt = ST_WAIT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (r_lat_cnt == 4'd1) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         default: w_state_nxt = RST_STATE;
      endcase
   end

   // Clear sweep counter and latency countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clr_cnt <= '0;
         r_lat_cnt <= 4'd0;
      end else begin
         if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
         end else begin
            r_clr_cnt <= '0;
         end
         if (w_accept) begin
            r_lat_cnt <= LAT_INIT;
         end else if (r_state == ST_WAIT) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
         end
      end
   end

   // Word array: clearing writes whole words, stores write only enabled lanes.
   // Not reset, so contents survive reset when clearing is disabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= 32'h0000_0000;
         end else if (w_do_store) begin
            for (int i = 0; i < 4; i++) begin
               if (w_be[i]) begin
                  r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
               end
            end
         end
      end
   end

   // Response path: capture on accept, release now (LATENCY=1) or at the end of WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0000_0000;
         r_resp_err   <= 1'b0;
         r_hold_rdata <= 32'h0000_0000;
         r_hold_err   <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         if (w_accept) begin
            r_hold_rdata <= w_resp_data;
            r_hold_err   <= w_err;
         end
         if (w_accept && !LONG_LAT) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_resp_data;
            r_resp_err   <= w_err;
         end else if ((r_state == ST_WAIT) && (r_lat_cnt == 4'd1)) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_hold_rdata;
            r_resp_err   <= r_hold_err;
         end
      end
   end

`ifdef DM_TRACE_EN
   logic [31:0] w_merged;

   // Word as it will look after the store, for the trace line.
   always_comb begin
      w_merged = w_rword;
      for (int i = 0; i < 4; i++) begin
         if (w_be[i]) begin
            w_merged[8*i +: 8] = w_wlanes[8*i +: 8];
         end else begin
            w_merged[8*i +: 8] = w_rword[8*i +: 8];
         end
      end
   end

   // Store trace; loads and rejected stores stay silent.
   always_ff @(posedge clk) begin
      if (w_do_store) begin
         $display("@%h: *%h <= %h", bus.req_pc, {bus.req_addr[31:2], 2'b00}, w_merged);
      end
   end
`else
   logic w_unused_pc;
   assign w_unused_pc = ^bus.req_pc;
`endif

   assign bus.req_ready  = w_ready;
   assign bus.busy       = ~w_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_dm_subword_mem.sv
// -----------------------------------------------------------------------------
// tb_dm_subword_mem
// Directed bench for dm_subword_mem. Three instances share one stimulus bus:
//   a: ADDR_W=6, LATENCY=1   b: ADDR_W=6, LATENCY=3   c: ADDR_W=6, LATENCY=4
// sel chooses which instance sees req_valid and whose response is observed.
// -----------------------------------------------------------------------------
module tb_dm_subword_mem;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, rst_c;
   int          sel;
   logic        s_valid, s_we, s_signed;
   logic [1:0]  s_size;
   logic [31:0] s_addr, s_wdata, s_pc;

   logic        m_ready, m_rvalid, m_err, m_busy;
   logic [31:0] m_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dm_subword_mem_if if_a ();
   dm_subword_mem_if if_b ();
   dm_subword_mem_if if_c ();

   assign if_a.req_valid = s_valid && (sel == 0);
   assign if_b.req_valid = s_valid && (sel == 1);
   assign if_c.req_valid = s_valid && (sel == 2);
   assign if_a.req_we = s_we;       assign if_b.req_we = s_we;       assign if_c.req_we = s_we;
   assign if_a.req_size = s_size;   assign if_b.req_size = s_size;   assign if_c.req_size = s_size;
   assign if_a.req_signed = s_signed; assign if_b.req_signed = s_signed; assign if_c.req_signed = s_signed;
   assign if_a.req_addr = s_addr;   assign if_b.req_addr = s_addr;   assign if_c.req_addr = s_addr;
   assign if_a.req_wdata = s_wdata; assign if_b.req_wdata = s_wdata; assign if_c.req_wdata = s_wdata;
   assign if_a.req_pc = s_pc;       assign if_b.req_pc = s_pc;       assign if_c.req_pc = s_pc;

   dm_subword_mem #(.ADDR_W(6), .LATENCY(1), .CLEAR_ON_RST(1)) u_dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
   dm_subword_mem #(.ADDR_W(6), .LATENCY(3), .CLEAR_ON_RST(1)) u_dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
   dm_subword_mem #(.ADDR_W(6), .LATENCY(4), .CLEAR_ON_RST(1)) u_dut_c (.clk(clk), .rst(rst_c), .bus(if_c));

   // Observe the selected instance.
   always_comb begin
      case (sel)
         1: begin
            m_ready = if_b.req_ready; m_rvalid = if_b.resp_valid;
            m_err = if_b.resp_err; m_busy = if_b.busy; m_rdata = if_b.resp_rdata;
         end
         2: begin
            m_ready = if_c.req_ready; m_rvalid = if_c.resp_valid;
            m_err = if_c.resp_err; m_busy = if_c.busy; m_rdata = if_c.resp_rdata;
         end
         default: begin
            m_ready = if_a.req_ready; m_rvalid = if_a.resp_valid;
            m_err = if_a.resp_err; m_busy = if_a.busy; m_rdata = if_a.resp_rdata;
         end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One complete transaction on instance d; waits (bounded) for ready and response.
   task automatic acc(input int d, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
      int n;
      sel = d;
      n = 0;
      @(negedge clk);
      while (!m_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready", {31'b0, m_ready}, 32'd1);
      s_valid = 1'b1; s_we = we; s_size = sz; s_signed = sg; s_addr = addr; s_wdata = wd;
      s_pc = 32'h0040_0000 + addr;
      @(posedge clk); #1;
      s_valid = 1'b0;
      n = 0;
      while (!m_rvalid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("resp_valid", {31'b0, m_rvalid}, 32'd1);
      rd = m_rdata;
      er = m_err;
   endtask

   logic [31:0] rd;
   logic        er;
   int          n;
   int          pulses;

   // Back-to-back vectors for LATENCY=1: {size, signed, addr, expected}
   logic [1:0]  bb_sz  [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
   logic        bb_sg  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] bb_ad  [4] = '{32'h10, 32'h20, 32'h11, 32'h12};
   logic [31:0] bb_ex  [4] = '{32'h80FF7F01, 32'hBEEF33AA, 32'h0000007F, 32'hFFFF80FF};
   // {req_ready, resp_valid} in cycles T+1..T+4 for LATENCY=3
   logic [1:0]  l3_ex  [4] = '{2'b00, 2'b00, 2'b11, 2'b10};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 0;
      s_valid = 1'b0; s_we = 1'b0; s_size = 2'b10; s_signed = 1'b0;
      s_addr = 32'h0; s_wdata = 32'h0; s_pc = 32'h0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // 1: reset + clear; data written before reset must be gone afterwards
      acc(0, 1'b1, 2'b10, 1'b0, 32'h3C, 32'hDEADBEEF, rd, er);
      acc(0, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, rd, er);
      chk("pre_rst_lw3c", rd, 32'hDEADBEEF);
      @(negedge clk); rst_a = 1'b1;
      @(posedge clk); #1; rst_a = 1'b0;
      chk("rst_ready", {31'b0, m_ready}, 32'd0);
      chk("rst_busy", {31'b0, m_busy}, 32'd1);
      chk("rst_rvalid", {31'b0, m_rvalid}, 32'd0);
      chk("rst_rdata", m_rdata, 32'h0);
      chk("rst_err", {31'b0, m_err}, 32'd0);
      n = 0;
      while (!m_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("clr_cycles", n, 32'd16);
      chk("idle_busy", {31'b0, m_busy}, 32'd0);
      acc(0, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, rd, er);
      chk("post_clr_lw3c", rd, 32'h0);

      // 2: sub-word loads
      acc(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, rd, er);
      chk("sw_rdata", rd, 32'h0);
      chk("sw_err", {31'b0, er}, 32'd0);
      acc(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er);
      chk("lb13", rd, 32'hFFFFFF80);
      acc(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er);
      chk("lbu13", rd, 32'h00000080);
      acc(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er);
      chk("lh12", rd, 32'hFFFF80FF);
      acc(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er);
      chk("lhu10", rd, 32'h00007F01);
      acc(0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, rd, er);
      chk("lw10_signed", rd, 32'h80FF7F01);

      // 3: partial stores merge into one word
      acc(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er);
      acc(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, rd, er);
      acc(0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h000000AA, rd, er);
      acc(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
      chk("lw20_merge", rd, 32'hBEEF33AA);

      // 4: misaligned and reserved-size accesses
      acc(0, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, rd, er);
      chk("lw21_err", {31'b0, er}, 32'd1);
      chk("lw21_rdata", rd, 32'h0);
      acc(0, 1'b1, 2'b01, 1'b0, 32'h23, 32'h00005555, rd, er);
      chk("sh23_err", {31'b0, er}, 32'd1);
      acc(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, er);
      chk("size11_err", {31'b0, er}, 32'd1);
      chk("size11_rdata", rd, 32'h0);
      acc(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
      chk("lw20_kept", rd, 32'hBEEF33AA);
      chk("lw20_noerr", {31'b0, er}, 32'd0);

      // 5a: LATENCY=1 back-to-back loads
      sel = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s_valid = 1'b1; s_we = 1'b0; s_size = bb_sz[i]; s_signed = bb_sg[i]; s_addr = bb_ad[i];
         @(posedge clk); #1;
         chk($sformatf("b2b_vld%0d", i), {31'b0, m_rvalid}, 32'd1);
         chk($sformatf("b2b_dat%0d", i), m_rdata, bb_ex[i]);
      end
      @(negedge clk); s_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_end", {31'b0, m_rvalid}, 32'd0);

      // 5b: LATENCY=3 timing of ready and resp_valid
      sel = 1;
      n = 0;
      @(negedge clk);
      while (!m_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      s_valid = 1'b1; s_we = 1'b0; s_size = 2'b10; s_signed = 1'b0; s_addr = 32'h0;
      @(posedge clk); #1;
      s_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("lat3_t%0d", k + 1), {30'b0, m_ready, m_rvalid}, {30'b0, l3_ex[k]});
         @(posedge clk); #1;
      end
      acc(1, 1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678, rd, er);
      acc(1, 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, rd, er);
      chk("lat3_lh0a", rd, 32'h00001234);

      // 6: reset while a LATENCY=4 request is in flight
      sel = 2;
      n = 0;
      @(negedge clk);
      while (!m_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      s_valid = 1'b1; s_we = 1'b0; s_size = 2'b10; s_signed = 1'b0; s_addr = 32'h0;
      @(posedge clk); #1;
      s_valid = 1'b0;
      chk("lat4_busy", {31'b0, m_ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk); rst_c = 1'b1;
      @(posedge clk); #1; rst_c = 1'b0;
      chk("midrst_ready", {31'b0, m_ready}, 32'd0);
      chk("midrst_busy", {31'b0, m_busy}, 32'd1);
      pulses = 0;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (m_rvalid) pulses++;
         if (m_ready && n == 0) n = k;
      end
      chk("midrst_no_resp", pulses, 32'd0);
      chk("midrst_reclear", n, 32'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
